// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Writer side of the SAP instruction path. Accepts a byte stream from an
//   external source (UART receiver, switch panel, ...) and writes it into the
//   SAP RAM over BUS. It uses the same mar_in / ram_in strobes that the
//   instruction decoder issues. The CPU is held off the bus while a load runs,
//   and a one-cycle cpu_rst pulse at the end restarts fetch at address 0.
//
// Ports
//   clk        : system clock, rising edge
//   cls        : asynchronous active-low reset
//   start      : load request, sampled only in IDLE
//   prog_len   : number of bytes to load (0 or > DEPTH means DEPTH)
//   byte_valid : source presents a byte on byte_data
//   byte_data  : program byte
//   byte_ready : loader accepts a byte this cycle
//   bus_oe     : loader drives BUS
//   bus_out    : BUS value (0 when bus_oe is low)
//   mar_in     : MAR load strobe
//   ram_in     : RAM write strobe
//   cpu_hold   : CPU must stay off BUS and not advance
//   cpu_rst    : one-cycle restart pulse for fetch counter and PC
//   busy       : load in progress
//   done       : one-cycle completion pulse
//   addr       : current write address
//
// Every output is a flop. Its next value is decoded from the next state, so
// each output lines up exactly with the state it belongs to. There is no
// combinational path from an input to an output.
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              cls,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              bus_oe,
    output logic [7:0]        bus_out,
    output logic              mar_in,
    output logic              ram_in,
    output logic              cpu_hold,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        SET_ADDR  = 3'd2,
        WRITE     = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_V    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_V      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] FULL_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [ADDR_W-1:0] last_r, last_s;
    logic [7:0]        data_r, data_s;
    logic [ADDR_W:0]   len_m1_s;
    logic [ADDR_W-1:0] len_last_s;

    logic              byte_ready_s, bus_oe_s, mar_in_s, ram_in_s;
    logic              cpu_hold_s, cpu_rst_s, busy_s, done_s;
    logic [7:0]        bus_out_s;

    // Last write address derived from the requested length; 0 and oversize mean a full RAM
    always_comb begin
        len_m1_s = prog_len - ONE_V;
        if ((prog_len == {(ADDR_W+1){1'b0}}) || (prog_len > DEPTH_V)) begin
            len_last_s = FULL_LAST;
        end else begin
            len_last_s = len_m1_s[ADDR_W-1:0];
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        last_s  = last_r;
        data_s  = data_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    addr_s  = {ADDR_W{1'b0}};
                    last_s  = len_last_s;
                    state_s = WAIT_BYTE;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_BYTE: begin
                if (byte_valid) begin
                    data_s  = byte_data;
                    state_s = SET_ADDR;
                end else begin
                    state_s = WAIT_BYTE;
                end
            end
            SET_ADDR: begin
                state_s = WRITE;
            end
            WRITE: begin
                if (addr_r == last_r) begin
                    state_s = DONE;
                end else begin
                    addr_s  = addr_r + ADDR_ONE;
                    state_s = WAIT_BYTE;
                end
            end
            DONE: begin
                addr_s  = {ADDR_W{1'b0}};
                state_s = IDLE;
            end
            default: begin
                addr_s  = {ADDR_W{1'b0}};
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register
    always_comb begin
        byte_ready_s = 1'b0;
        bus_oe_s     = 1'b0;
        bus_out_s    = 8'h00;
        mar_in_s     = 1'b0;
        ram_in_s     = 1'b0;
        cpu_hold_s   = 1'b0;
        cpu_rst_s    = 1'b0;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        case (state_s)
            IDLE: begin
                cpu_hold_s = 1'b0;
            end
            WAIT_BYTE: begin
                byte_ready_s = 1'b1;
                cpu_hold_s   = 1'b1;
                busy_s       = 1'b1;
            end
            SET_ADDR: begin
                bus_oe_s   = 1'b1;
                bus_out_s  = {{(8-ADDR_W){1'b0}}, addr_s};
                mar_in_s   = 1'b1;
                cpu_hold_s = 1'b1;
                busy_s     = 1'b1;
            end
            WRITE: begin
                bus_oe_s   = 1'b1;
                bus_out_s  = data_s;
                ram_in_s   = 1'b1;
                cpu_hold_s = 1'b1;
                busy_s     = 1'b1;
            end
            DONE: begin
                done_s     = 1'b1;
                cpu_rst_s  = 1'b1;
                cpu_hold_s = 1'b1;
            end
            default: begin
                cpu_hold_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge cls) begin
        if (!cls) begin
            state_r <= IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            last_r  <= {ADDR_W{1'b0}};
            data_r  <= 8'h00;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            last_r  <= last_s;
            data_r  <= data_s;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge cls) begin
        if (!cls) begin
            byte_ready <= 1'b0;
            bus_oe     <= 1'b0;
            bus_out    <= 8'h00;
            mar_in     <= 1'b0;
            ram_in     <= 1'b0;
            cpu_hold   <= 1'b0;
            cpu_rst    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr       <= {ADDR_W{1'b0}};
        end else begin
            byte_ready <= byte_ready_s;
            bus_oe     <= bus_oe_s;
            bus_out    <= bus_out_s;
            mar_in     <= mar_in_s;
            ram_in     <= ram_in_s;
            cpu_hold   <= cpu_hold_s;
            cpu_rst    <= cpu_rst_s;
            busy       <= busy_s;
            done       <= done_s;
            addr       <= addr_s;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//   Directed self-checking bench for prog_loader. All outputs are packed into
//   one 20-bit vector {byte_ready, bus_oe, bus_out[7:0], mar_in, ram_in,
//   cpu_hold, cpu_rst, busy, done, addr[3:0]}, which is compared with the
//   vector expected for the state the loader should be in.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    logic       clk;
    logic       cls;
    logic       start;
    logic [4:0] prog_len;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready, bus_oe, mar_in, ram_in, cpu_hold, cpu_rst, busy, done;
    logic [7:0] bus_out;
    logic [3:0] addr;

    int n_cmp;
    int n_err;
    logic [7:0] vals [16];

    prog_loader #(.ADDR_W(4), .DEPTH(16)) dut (
        .clk        (clk),
        .cls        (cls),
        .start      (start),
        .prog_len   (prog_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .bus_oe     (bus_oe),
        .bus_out    (bus_out),
        .mar_in     (mar_in),
        .ram_in     (ram_in),
        .cpu_hold   (cpu_hold),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .addr       (addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] v_idle();
        return 20'h00000;
    endfunction

    // byte_ready, cpu_hold, busy
    function automatic logic [19:0] v_wait(input logic [3:0] a);
        return {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a};
    endfunction

    // bus_oe, bus_out = address, mar_in, cpu_hold, busy
    function automatic logic [19:0] v_set(input logic [3:0] a);
        return {1'b0, 1'b1, {4'h0, a}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a};
    endfunction

    // bus_oe, bus_out = data, ram_in, cpu_hold, busy
    function automatic logic [19:0] v_write(input logic [3:0] a, input logic [7:0] d);
        return {1'b0, 1'b1, d, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, a};
    endfunction

    // cpu_hold, cpu_rst, done; busy low
    function automatic logic [19:0] v_done(input logic [3:0] a);
        return {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a};
    endfunction

    task automatic chk(input string tag, input logic [19:0] expv);
        logic [19:0] obs;
        obs = {byte_ready, bus_oe, bus_out, mar_in, ram_in, cpu_hold, cpu_rst, busy, done, addr};
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete load of n bytes taken from vals[]. A stall of five
    // cycles is inserted before byte number stall_at. With poke set, start
    // and a wrong byte_data are presented during SET_ADDR/WRITE, and both
    // must be ignored.
    task automatic run_load(input string tag, input int n, input logic [4:0] plen,
                            input int stall_at, input bit poke);
        start      = 1'b1;
        prog_len   = plen;
        byte_valid = 1'b1;     // presented together with start: must not be taken
        byte_data  = 8'h77;
        tick();
        start = 1'b0;
        chk({tag, " first wait"}, v_wait(4'd0));
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                byte_valid = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk({tag, " stall"}, v_wait(4'(i)));
                end
            end
            byte_valid = 1'b1;
            byte_data  = vals[i];
            tick();
            chk({tag, " set_addr"}, v_set(4'(i)));
            if (poke) begin
                start     = 1'b1;
                byte_data = ~vals[i];
            end
            tick();
            chk({tag, " write"}, v_write(4'(i), vals[i]));
            tick();
            start = 1'b0;
            if (i < n - 1) begin
                chk({tag, " next wait"}, v_wait(4'(i + 1)));
            end else begin
                chk({tag, " done"}, v_done(4'(i)));
            end
        end
        tick();
        chk({tag, " idle after done"}, v_idle());
        tick();
        chk({tag, " no extra byte_ready"}, v_idle());
        byte_valid = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        cls        = 1'b0;
        start      = 1'b0;
        prog_len   = 5'd0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            start      = 1'($urandom);
            prog_len   = 5'($urandom);
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            tick();
            chk("reset held", v_idle());
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        cls        = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle after reset", v_idle());
        end

        // Three-byte load, byte_valid held high
        vals[0] = 8'h1E;
        vals[1] = 8'h2F;
        vals[2] = 8'hF0;
        run_load("len3", 3, 5'd3, 99, 1'b0);

        // Full loads: prog_len 0 and oversize 20 both mean 16 bytes
        for (int i = 0; i < 16; i++) begin
            vals[i] = 8'(i * 17) ^ 8'hA5;
        end
        run_load("len0", 16, 5'd0, 99, 1'b0);
        run_load("len20", 16, 5'd20, 99, 1'b0);

        // Exact full length 16, stalled source plus ignored start/byte_valid
        run_load("len16 stall", 16, 5'd16, 2, 1'b1);
        run_load("len4 poke", 4, 5'd4, 1, 1'b1);

        // Reset during the WRITE of the second byte
        start      = 1'b1;
        prog_len   = 5'd5;
        byte_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("rst load wait0", v_wait(4'd0));
        byte_valid = 1'b1;
        byte_data  = 8'h3C;
        tick();
        chk("rst load set0", v_set(4'd0));
        tick();
        chk("rst load write0", v_write(4'd0, 8'h3C));
        byte_data = 8'h5A;
        tick();
        chk("rst load wait1", v_wait(4'd1));
        tick();
        chk("rst load set1", v_set(4'd1));
        tick();
        chk("rst load write1", v_write(4'd1, 8'h5A));
        #2;
        cls = 1'b0;
        #1;
        chk("async reset mid-write", v_idle());
        tick();
        chk("reset held after abort", v_idle());
        byte_valid = 1'b0;
        cls        = 1'b1;
        tick();
        chk("idle after abort", v_idle());
        vals[0] = 8'hC3;
        vals[1] = 8'h81;
        run_load("reload", 2, 5'd2, 99, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
